// File: rtl/gemm_pkg.sv
// -----------------------------------------------------------------------------
// gemm_pkg
// Shared definitions for the 2x2 output-stationary GEMM array: default operand
// and accumulator widths, the array dimension, and the drain-side FSM state
// encoding used by gemm_output_manager and its testbench.
// -----------------------------------------------------------------------------
package gemm_pkg;

  // Default operand width fed into the MACs by the input manager
  localparam int GEMM_OP_WIDTH  = 8;

  // Default accumulator / result element width
  localparam int GEMM_ACC_WIDTH = 20;

  // The array is square: GEMM_DIM x GEMM_DIM MACs
  localparam int GEMM_DIM       = 2;

  // Width of the drain delay counter; holds DRAIN_DELAY-1 for DRAIN_DELAY 1..15
  localparam int GEMM_DRAIN_CNT_WIDTH = 4;

  // Drain FSM states
  //   ST_IDLE   : waiting for compute_last
  //   ST_WAIT   : counting down until the last operands have left the MACs
  //   ST_DRAIN0 : presenting result row 0 (C11, C12)
  //   ST_DRAIN1 : presenting result row 1 (C21, C22)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN0 = 2'd2,
    ST_DRAIN1 = 2'd3
  } drain_state_e;

endpackage

// File: rtl/gemm_output_manager.sv
// -----------------------------------------------------------------------------
// gemm_output_manager
// Drain side of the 2x2 output-stationary GEMM array. After compute_last, it
// waits DRAIN_DELAY cycles for the final operands to ripple through the MACs,
// snapshots the four accumulators while pulsing mac_clear, then streams the
// 2x2 result out row by row over a valid/ready interface.
//
// Parameters
//   ACC_WIDTH   : accumulator / result element width
//   DRAIN_DELAY : cycles from compute_last sampled to accumulators final (1..15)
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   compute_last in   pulse: last operand column/row presented this cycle
//   mac_XY_acc   in   accumulator of MAC at row X, column Y
//   mac_clear    out  one-cycle pulse; MACs zero accumulators on next edge
//   c_row        out  result row; low half = column 1, high half = column 2
//   c_row_valid  out  c_row holds a valid row
//   c_row_ready  in   downstream accepts c_row
//   c_row_last   out  high with the second (final) row
//   busy         out  high whenever the FSM is not idle
//   overrun      out  sticky: compute_last arrived while busy
// -----------------------------------------------------------------------------
module gemm_output_manager
  import gemm_pkg::*;
#(
  parameter int ACC_WIDTH   = GEMM_ACC_WIDTH,
  parameter int DRAIN_DELAY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   compute_last,
  input  logic [ACC_WIDTH-1:0]   mac_11_acc,
  input  logic [ACC_WIDTH-1:0]   mac_12_acc,
  input  logic [ACC_WIDTH-1:0]   mac_21_acc,
  input  logic [ACC_WIDTH-1:0]   mac_22_acc,
  output logic                   mac_clear,
  output logic [2*ACC_WIDTH-1:0] c_row,
  output logic                   c_row_valid,
  input  logic                   c_row_ready,
  output logic                   c_row_last,
  output logic                   busy,
  output logic                   overrun
);

  localparam int BUF_DEPTH = GEMM_DIM * GEMM_DIM;

  // Counter starts at DRAIN_DELAY-1 so that the cycle it reads zero is the
  // last WAIT cycle, i.e. the cycle in which mac_clear is high.
  localparam logic [GEMM_DRAIN_CNT_WIDTH-1:0] CNT_LOAD =
    GEMM_DRAIN_CNT_WIDTH'(DRAIN_DELAY - 1);

  // Result buffer index map: 0=C11, 1=C12, 2=C21, 3=C22
  localparam int IDX_C11 = 0;
  localparam int IDX_C12 = 1;
  localparam int IDX_C21 = 2;
  localparam int IDX_C22 = 3;

  drain_state_e                      state_q, state_d;
  logic [GEMM_DRAIN_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]              buf_q [BUF_DEPTH];
  logic [ACC_WIDTH-1:0]              buf_d [BUF_DEPTH];
  logic                              overrun_q, overrun_d;

  logic                              mac_clear_q, mac_clear_d;
  logic [2*ACC_WIDTH-1:0]            c_row_q, c_row_d;
  logic                              c_row_valid_q, c_row_valid_d;
  logic                              c_row_last_q, c_row_last_d;
  logic                              busy_q, busy_d;

  logic                              row_accept;

  // A row leaves only when it is both offered and accepted
  assign row_accept = c_row_valid_q && c_row_ready;

  // Next-state logic for the drain sequencer, counter, snapshot buffer and
  // overrun flag. Any compute_last seen outside IDLE is dropped but flagged,
  // including one that coincides with the final row handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    overrun_d = overrun_q;

    if (compute_last && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (compute_last) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          // Accumulators are final this cycle; grab them on the same edge
          // that the MACs see mac_clear and zero themselves.
          buf_d[IDX_C11] = mac_11_acc;
          buf_d[IDX_C12] = mac_12_acc;
          buf_d[IDX_C21] = mac_21_acc;
          buf_d[IDX_C22] = mac_22_acc;
          state_d        = ST_DRAIN0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DRAIN0: begin
        if (row_accept) begin
          state_d = ST_DRAIN1;
        end
      end

      ST_DRAIN1: begin
        if (row_accept) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values are derived from the upcoming state so they can be
  // registered and still line up with the state they describe. This keeps
  // c_row_ready out of any combinational path to the outputs.
  always_comb begin
    mac_clear_d   = (state_d == ST_WAIT) && (cnt_d == '0);
    c_row_valid_d = (state_d == ST_DRAIN0) || (state_d == ST_DRAIN1);
    c_row_last_d  = (state_d == ST_DRAIN1);
    busy_d        = (state_d != ST_IDLE);

    c_row_d = '0;
    case (state_d)
      ST_DRAIN0: c_row_d = {buf_d[IDX_C12], buf_d[IDX_C11]};
      ST_DRAIN1: c_row_d = {buf_d[IDX_C22], buf_d[IDX_C21]};
      default:   c_row_d = '0;
    endcase
  end

  // Drain FSM state and registered outputs. Reset aborts any transfer in
  // flight and clears the snapshot and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      overrun_q     <= 1'b0;
      mac_clear_q   <= 1'b0;
      c_row_q       <= '0;
      c_row_valid_q <= 1'b0;
      c_row_last_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
      overrun_q     <= overrun_d;
      mac_clear_q   <= mac_clear_d;
      c_row_q       <= c_row_d;
      c_row_valid_q <= c_row_valid_d;
      c_row_last_q  <= c_row_last_d;
      busy_q        <= busy_d;
    end
  end

  assign mac_clear   = mac_clear_q;
  assign c_row       = c_row_q;
  assign c_row_valid = c_row_valid_q;
  assign c_row_last  = c_row_last_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/gemm_output_manager.md
# gemm_output_manager

Drain side of the 2x2 output-stationary GEMM array. Waits for the last operands of a GEMM to finish propagating through the MACs, then snapshots the four accumulators and pulses a clear to the MACs. It then streams the 2x2 result out row by row over a valid/ready interface. It sits between the MAC array and the result writeback path, mirroring the skewing input manager on the operand side.

## Interface
Parameters:
- ACC_WIDTH, 20, width of each MAC accumulator and each result element
- DRAIN_DELAY, 4, cycles from compute_last sampled to all accumulators final; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- compute_last  in  1  pulse: last operand column/row is presented to the input manager this cycle
- mac_11_acc, mac_12_acc, mac_21_acc, mac_22_acc  in  ACC_WIDTH each  MAC accumulator values, Cij
- mac_clear  out  1  one-cycle pulse; MACs zero their accumulators on the next edge
- c_row  out  2*ACC_WIDTH  result row; [0+:ACC_WIDTH]=column 1, [ACC_WIDTH+:ACC_WIDTH]=column 2
- c_row_valid  out  1  c_row holds a valid row
- c_row_ready  in  1  downstream accepts c_row
- c_row_last  out  1  high with the second (final) row
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky: compute_last arrived while busy

## Operation
- States: IDLE, WAIT, DRAIN0, DRAIN1.
- IDLE: compute_last=1 loads the delay counter with DRAIN_DELAY-1 and moves to WAIT.
- WAIT: counter decrements each cycle. In the cycle the counter reads 0:
  - mac_clear=1.
  - On that edge, the result buffer captures {C11,C12,C21,C22}.
  - The FSM moves to DRAIN0.
- DRAIN0: c_row={C12,C11}, c_row_valid=1, c_row_last=0. On valid&&ready, moves to DRAIN1.
- DRAIN1: c_row={C22,C21}, c_row_valid=1, c_row_last=1. On valid&&ready, moves to IDLE.
- Handshake: once raised, c_row_valid and c_row stay stable until accepted. ready may be high before valid. No combinational path from c_row_ready to c_row_valid.
- compute_last in any non-IDLE state is ignored and sets overrun=1. Overrun clears only on reset.
- The buffer is a snapshot. MAC values changing after capture do not affect c_row.
- Reset, at any time including mid-drain, aborts the transfer with no further valid.
  - After the reset edge: state=IDLE, counter=0, buffer=0.
  - Outputs after reset: mac_clear=0, c_row_valid=0, c_row_last=0, c_row=0, busy=0, overrun=0.
- Accumulators are passed through unmodified, with no truncation or sign handling.

## Timing
- compute_last is sampled at edge t. mac_clear is high during cycle t+DRAIN_DELAY-1, and capture happens at edge t+DRAIN_DELAY.
- With DRAIN_DELAY=1, WAIT lasts one cycle: mac_clear is high in the cycle after compute_last.
- The first c_row_valid is high in the cycle after capture.
- With ready held high, row 0 and row 1 occupy two consecutive cycles. busy falls the cycle after row 1 is accepted.
- IDLE-to-IDLE minimum: DRAIN_DELAY+2 cycles.
- A new compute_last is accepted in the first IDLE cycle after DRAIN1 completes.
- A compute_last coinciding with the final DRAIN1 handshake is still a non-IDLE arrival: it is ignored and sets overrun.
- All outputs are registered or decoded from registered state only.

## Structure
- Shared package gemm_pkg holds:
  - the default OP_WIDTH and ACC_WIDTH constants;
  - the array dimension constant (2);
  - the drain-state enum typedef, for use by this block and its bench.
- Single module. The 4-entry result buffer, delay counter and FSM are inline, with no sub-module.

## Test plan
- Reset sequence: hold reset 3 cycles with compute_last=1 -> all outputs 0, busy=0.
- Basic drain: DRAIN_DELAY=4, MAC values C11=1, C12=2, C21=3, C22=4, compute_last at edge 10, ready=1.
  - Required: mac_clear high in cycle 13.
  - Required: c_row={2,1} at cycle 14 with last=0, then {4,3} at cycle 15 with last=1.
  - Required: busy=0 at cycle 16.
- Backpressure: same stimulus with ready=0 for 5 cycles, then 1 -> row0 held stable for 5 cycles, then each row is accepted exactly once.
- Snapshot: change all MAC inputs to 0xFFFFF right after capture -> c_row still carries 1..4.
- Overrun: pulse compute_last during WAIT and again during DRAIN1 -> overrun=1 and stays set.
  - Required: only one result pair is emitted.
  - Required: a compute_last issued after returning to IDLE then drains normally.
- Mid-drain reset: reset during DRAIN0 with ready=0 -> c_row_valid=0 after the reset edge, no DRAIN1 row, and the next GEMM drains normally.
